// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Two-port round-robin arbiter sharing the CPU-side port of the L2 cache
//   between the L1 instruction cache (port 0) and the L1 data cache (port 1).
//   One request is captured at a time, driven onto the L2 level-sensitive
//   read/write interface, and the returned block is handed back to the
//   winning port with a one-cycle ready pulse. Saturating per-port grant
//   counters record completed transactions.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_addr               request address
//   req{0,1}_data_in            write block
//   req{0,1}_read/_write        level requests, held until the ready pulse
//   req{0,1}_ready              one-cycle completion pulse
//   req{0,1}_data_out           response block, held after the pulse
//   l2_cache_addr/_data_in      latched command address / write block
//   l2_cache_read/_write        L2 command levels
//   l2_cache_data_out           L2 response block
//   l2_cache_ready              L2 completion pulse
//   grant_cnt0/1                saturating completed-transaction counters
module l2_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int L1_BLOCK_SIZE = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [ADDR_WIDTH-1:0]                        req0_addr,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     req0_data_in,
    input  logic                                         req0_read,
    input  logic                                         req0_write,
    output logic                                         req0_ready,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     req0_data_out,
    input  logic [ADDR_WIDTH-1:0]                        req1_addr,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     req1_data_in,
    input  logic                                         req1_read,
    input  logic                                         req1_write,
    output logic                                         req1_ready,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     req1_data_out,
    output logic [ADDR_WIDTH-1:0]                        l2_cache_addr,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     l2_cache_data_in,
    output logic                                         l2_cache_read,
    output logic                                         l2_cache_write,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     l2_cache_data_out,
    input  logic                                         l2_cache_ready,
    output logic [CNT_WIDTH-1:0]                         grant_cnt0,
    output logic [CNT_WIDTH-1:0]                         grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic last_grant;
    logic grant_port;
    logic mask_active;
    logic mask_port;
    logic op_read;
    logic op_write;

    logic req0_active;
    logic req1_active;
    logic grant_valid;
    logic win_port;

    // The port served in the previous transaction is ignored for one IDLE
    // cycle so its request, which drops one cycle late, is not re-granted.
    assign req0_active = (req0_read | req0_write) & ~(mask_active & ~mask_port);
    assign req1_active = (req1_read | req1_write) & ~(mask_active &  mask_port);
    assign grant_valid = req0_active | req1_active;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        win_port = 1'b0;
        if (req0_active && req1_active) begin
            win_port = ~last_grant;
        end else if (req1_active) begin
            win_port = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. There is no abort path: ISSUE waits for the L2.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   if (l2_cache_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command capture, arbitration history and the one-cycle mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant       <= 1'b1;
            grant_port       <= 1'b0;
            mask_active      <= 1'b0;
            mask_port        <= 1'b0;
            op_read          <= 1'b0;
            op_write         <= 1'b0;
            l2_cache_addr    <= '0;
            l2_cache_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask_active <= 1'b0;
                    if (grant_valid) begin
                        last_grant <= win_port;
                        grant_port <= win_port;
                        if (win_port) begin
                            l2_cache_addr    <= req1_addr;
                            l2_cache_data_in <= req1_data_in;
                            op_write         <= req1_write;
                            op_read          <= req1_read & ~req1_write;
                        end else begin
                            l2_cache_addr    <= req0_addr;
                            l2_cache_data_in <= req0_data_in;
                            op_write         <= req0_write;
                            op_read          <= req0_read & ~req0_write;
                        end
                    end
                end
                RESP: begin
                    mask_active <= 1'b1;
                    mask_port   <= grant_port;
                end
                default: ;
            endcase
        end
    end

    // Response capture and saturating grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_data_out <= '0;
            req1_data_out <= '0;
            grant_cnt0    <= '0;
            grant_cnt1    <= '0;
        end else if (state == ISSUE && l2_cache_ready) begin
            if (grant_port) begin
                req1_data_out <= l2_cache_data_out;
                if (!(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
            end else begin
                req0_data_out <= l2_cache_data_out;
                if (!(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
            end
        end
    end

    // Output decode. The L2 command is gated by ready so the L2 does not
    // relaunch in the cycle it completes.
    always_comb begin
        l2_cache_read  = 1'b0;
        l2_cache_write = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        case (state)
            ISSUE: begin
                l2_cache_read  = op_read  & ~l2_cache_ready;
                l2_cache_write = op_write & ~l2_cache_ready;
            end
            RESP: begin
                req0_ready = ~grant_port;
                req1_ready =  grant_port;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter
//   Randomised scoreboard bench for l2_arbiter. A bench-side L2 model
//   answers commands with an address-derived block after a chosen latency.
//   A timestamp-based reference model decides which port should win each
//   grant and when commands and ready pulses are due; a separate monitor
//   pops the expected transaction whenever a ready pulse appears.
module tb_l2_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef logic [BS-1:0][DW-1:0] block_t;
    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        block_t        data;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [AW-1:0] req_addr [2];
    block_t        req_din  [2];
    logic          req_rd   [2];
    logic          req_wr   [2];

    logic          req0_ready, req1_ready;
    block_t        req0_data_out, req1_data_out;
    logic [AW-1:0] l2_cache_addr;
    block_t        l2_cache_data_in;
    logic          l2_cache_read, l2_cache_write;
    block_t        l2_data_out;
    logic          l2_ready;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    txn_t exp_q[$];

    l2_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .L1_BLOCK_SIZE(BS), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_addr(req_addr[0]), .req0_data_in(req_din[0]),
        .req0_read(req_rd[0]), .req0_write(req_wr[0]),
        .req0_ready(req0_ready), .req0_data_out(req0_data_out),
        .req1_addr(req_addr[1]), .req1_data_in(req_din[1]),
        .req1_read(req_rd[1]), .req1_write(req_wr[1]),
        .req1_ready(req1_ready), .req1_data_out(req1_data_out),
        .l2_cache_addr(l2_cache_addr), .l2_cache_data_in(l2_cache_data_in),
        .l2_cache_read(l2_cache_read), .l2_cache_write(l2_cache_write),
        .l2_cache_data_out(l2_data_out), .l2_cache_ready(l2_ready),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block returned by the bench L2 for a given address.
    function automatic block_t l2Block(input logic [AW-1:0] a);
        block_t b;
        for (int i = 0; i < BS; i++) begin
            b[i] = (a * 32'd2654435761) ^ (32'(i) << 24) ^ 32'(i);
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [BS*DW-1:0] act,
                               input logic [BS*DW-1:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Bench L2: commands are sampled mid-cycle, ready is returned
    // 'latency' cycles after the first command cycle.
    int   fixed_lat = 0;
    logic cmd_seen;
    logic [AW-1:0] cmd_addr;
    bit   l2_busy;
    int   l2_left;

    always @(negedge clk) begin
        cmd_seen <= rst_n && (l2_cache_read || l2_cache_write);
        cmd_addr <= l2_cache_addr;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_ready    <= 1'b0;
            l2_busy     <= 1'b0;
            l2_left     <= 0;
            l2_data_out <= '0;
        end else begin
            l2_ready <= 1'b0;
            if (!l2_busy) begin
                if (cmd_seen) begin
                    l2_busy <= 1'b1;
                    l2_left <= ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(5, 2))) - 1;
                end
            end else if (l2_left == 1) begin
                l2_ready    <= 1'b1;
                l2_data_out <= l2Block(cmd_addr);
                l2_busy     <= 1'b0;
            end else begin
                l2_left <= l2_left - 1;
            end
        end
    end

    // Reference model, evaluated mid-cycle. It tracks times rather than
    // states: when the arbiter is next free, which cycle is masked for which
    // port, and when the ready pulse is owed.
    bit   m_busy;
    int   m_port, m_grant_cyc, m_resp_cyc, m_free, m_mask_cyc, m_mask_port, m_last, m_c;
    int   m_cnt [2];
    bit   m_write;
    txn_t m_cur;
    logic exp_rd, exp_wr, exp_rdy0, exp_rdy1;
    bit   e0, e1;

    initial begin : model
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
                m_free = 0; m_mask_cyc = -1; m_resp_cyc = -1;
                exp_q.delete();
            end else begin
                m_c = cyc;
                checkOutput("grant_cnt0", grant_cnt0, m_cnt[0]);
                checkOutput("grant_cnt1", grant_cnt1, m_cnt[1]);
                exp_rd = 0; exp_wr = 0; exp_rdy0 = 0; exp_rdy1 = 0;
                if (m_busy) begin
                    if (m_resp_cyc < 0 && m_c > m_grant_cyc) begin
                        checkOutput("l2_cache_addr", l2_cache_addr, m_cur.addr);
                        checkOutput("l2_cache_data_in", l2_cache_data_in, m_cur.data);
                        if (l2_ready) begin
                            m_resp_cyc = m_c + 1;
                            m_free = m_c + 2;
                            m_mask_cyc = m_c + 2;
                            m_mask_port = m_port;
                            if (m_cnt[m_port] < CNT_MAX) m_cnt[m_port]++;
                        end else begin
                            exp_wr = m_write;
                            exp_rd = !m_write;
                        end
                    end else if (m_c == m_resp_cyc) begin
                        if (m_port == 0) exp_rdy0 = 1; else exp_rdy1 = 1;
                        m_busy = 0;
                    end
                end
                checkOutput("l2_cache_read", l2_cache_read, exp_rd);
                checkOutput("l2_cache_write", l2_cache_write, exp_wr);
                checkOutput("req0_ready", req0_ready, exp_rdy0);
                checkOutput("req1_ready", req1_ready, exp_rdy1);
                if (!m_busy && m_c >= m_free) begin
                    e0 = (req_rd[0] || req_wr[0]) && !(m_c == m_mask_cyc && m_mask_port == 0);
                    e1 = (req_rd[1] || req_wr[1]) && !(m_c == m_mask_cyc && m_mask_port == 1);
                    if (e0 || e1) begin
                        m_port = (e0 && e1) ? ((m_last == 0) ? 1 : 0) : (e0 ? 0 : 1);
                        m_last = m_port;
                        m_busy = 1;
                        m_grant_cyc = m_c;
                        m_resp_cyc = -1;
                        m_write = req_wr[m_port];
                        m_cur.port = m_port;
                        m_cur.addr = req_addr[m_port];
                        m_cur.data = req_din[m_port];
                        exp_q.push_back(m_cur);
                    end
                end
            end
        end
    end

    task automatic scoreboardCheck(input int p, input block_t d);
        txn_t t;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_ready: got ready on port %0d, expected none pending", p);
        end else begin
            t = exp_q.pop_front();
            checkOutput("ready_port", p, t.port);
            checkOutput("data_out", d, l2Block(t.addr));
        end
    endtask

    // Monitor: pops the scoreboard whenever a ready pulse is presented.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req0_ready) scoreboardCheck(0, req0_data_out);
                if (req1_ready) scoreboardCheck(1, req1_data_out);
            end
        end
    end

    // Requester for one port. opmode: 0 random, 1 read, 2 write, 3 read+write.
    // Continuous mode presents the next request straight after the ready.
    task automatic applyStimulus(input int port, input int count, input bit continuous,
                                 input int opmode, input bit fix_addr,
                                 input logic [AW-1:0] addr_val, input bit incr_data);
        bit got;
        block_t d;
        int op;
        @(posedge clk); #1;
        for (int k = 0; k < count; k++) begin
            for (int i = 0; i < BS; i++) d[i] = incr_data ? 32'(i) : $urandom();
            req_addr[port] = fix_addr ? addr_val : $urandom();
            req_din[port] = d;
            op = (opmode == 0) ? int'($urandom_range(3, 1)) : opmode;
            req_rd[port] = (op == 1 || op == 3);
            req_wr[port] = (op == 2 || op == 3);
            got = 0;
            for (int w = 0; w < 400 && !got; w++) begin
                @(negedge clk);
                if ((port == 0) ? req0_ready : req1_ready) got = 1;
            end
            tests++;
            if (!got) begin
                fails++;
                $display("[TB] FAIL ready_timeout: port %0d got no ready, expected one within 400 cycles", port);
                req_rd[port] = 0; req_wr[port] = 0;
                return;
            end
            @(posedge clk); #1;
            if (!continuous || k == count - 1) begin
                req_rd[port] = 0; req_wr[port] = 0;
                if (!continuous) repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1;
    endtask

    bit seen_cmd;

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_addr[p] = '0; req_din[p] = '0; req_rd[p] = 0; req_wr[p] = 0;
        end
        rst_n = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req0_ready", req0_ready, 0);
        checkOutput("rst_req1_ready", req1_ready, 0);
        checkOutput("rst_req0_data_out", req0_data_out, 0);
        checkOutput("rst_req1_data_out", req1_data_out, 0);
        checkOutput("rst_l2_addr", l2_cache_addr, 0);
        checkOutput("rst_l2_data_in", l2_cache_data_in, 0);
        checkOutput("rst_l2_read", l2_cache_read, 0);
        checkOutput("rst_l2_write", l2_cache_write, 0);
        checkOutput("rst_cnt0", grant_cnt0, 0);
        checkOutput("rst_cnt1", grant_cnt1, 0);
        @(posedge clk); #1;
        rst_n = 1;

        $display("[TB] single read on port 0, L2 latency 6");
        fixed_lat = 6;
        applyStimulus(0, 1, 0, 1, 1, 32'h0000_1040, 0);
        checkOutput("single_cnt0", grant_cnt0, 1);
        fixed_lat = 0;
        doReset();

        $display("[TB] both ports continuous, alternating grants");
        fork
            applyStimulus(0, 4, 1, 0, 0, '0, 0);
            applyStimulus(1, 4, 1, 0, 0, '0, 0);
        join
        checkOutput("alt_cnt0", grant_cnt0, 4);
        checkOutput("alt_cnt1", grant_cnt1, 4);

        $display("[TB] port 1 write and read+write");
        applyStimulus(1, 1, 0, 2, 1, 32'h0000_2000, 1);
        applyStimulus(1, 1, 0, 3, 1, 32'h0000_2000, 1);
        checkOutput("write_cnt1", grant_cnt1, 6);

        $display("[TB] port 0 continuous, port 1 idle");
        applyStimulus(0, 5, 1, 0, 0, '0, 0);
        checkOutput("cont_cnt0", grant_cnt0, 9);

        $display("[TB] random traffic up to counter saturation");
        fork
            applyStimulus(0, 20, 0, 0, 0, '0, 0);
            applyStimulus(1, 20, 0, 0, 0, '0, 0);
        join
        checkOutput("sat_cnt0", grant_cnt0, CNT_MAX);
        checkOutput("sat_cnt1", grant_cnt1, CNT_MAX);

        $display("[TB] reset during ISSUE");
        fixed_lat = 6;
        @(posedge clk); #1;
        req_addr[0] = 32'h0000_3000;
        req_din[0] = '0;
        req_rd[0] = 1;
        seen_cmd = 0;
        for (int w = 0; w < 20 && !seen_cmd; w++) begin
            @(negedge clk);
            if (l2_cache_read) seen_cmd = 1;
        end
        checkOutput("midrst_cmd_up", seen_cmd, 1);
        #2;
        rst_n = 0;
        req_rd[0] = 0;
        #1;
        checkOutput("midrst_l2_read", l2_cache_read, 0);
        checkOutput("midrst_l2_write", l2_cache_write, 0);
        checkOutput("midrst_req0_ready", req0_ready, 0);
        checkOutput("midrst_cnt0", grant_cnt0, 0);
        checkOutput("midrst_cnt1", grant_cnt1, 0);
        checkOutput("midrst_l2_addr", l2_cache_addr, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1;
        fixed_lat = 0;
        repeat (10) @(posedge clk);
        applyStimulus(1, 1, 0, 1, 0, '0, 0);
        checkOutput("post_rst_cnt1", grant_cnt1, 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 40000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
